uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single uart_tx transmitter among NUM_REQ byte requesters, for example the echo path, a status reporter and a command responder. It sits between the requesters and uart_tx, and drives uart_tx's tx_data and tx_start. It sequences each byte through start, busy-acknowledge and completion. It enforces an optional inter-byte gap and recovers from a transmitter that never goes busy.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_W, 2, width of grant index; must be >= clog2(NUM_REQ)
BUSY_TIMEOUT, 16, cycles allowed after tx_start for tx_busy to rise before abort
GAP_CYCLES, 0, idle cycles inserted after each completed byte (0 = none)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester byte request; held high until ack
req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]; stable while req[i]=1
ack  out  NUM_REQ  one-cycle pulse: byte of requester i latched
done  out  NUM_REQ  one-cycle pulse: byte of requester i fully transmitted
err  out  1  one-cycle pulse: busy timeout abort
tx_data  out  8  to uart_tx tx_data
tx_start  out  1  to uart_tx tx_start; single-cycle pulse
tx_busy  in  1  from uart_tx
active_id  out  ID_W  index of current/last granted requester

Behaviour:
- Reset (rst_n=0 at a clk edge) applies in any state, including mid-byte. Results: state=IDLE; ack=0, done=0, err=0, tx_start=0, tx_data=8'h00, active_id=0; rr pointer=0; counters=0. A byte in flight in uart_tx is not cancelled by this block.
- All outputs are registered.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req bit is set and tx_busy=0, pick the winner round-robin.
  - Search begins at rr pointer and wraps modulo NUM_REQ.
  - Next cycle: tx_data=req_data[winner], tx_start=1, ack[winner]=1, active_id=winner, state=START.
  - Grant latency is 1 cycle from req sampled.
  - If tx_busy=1 in IDLE, no grant is made and the FSM waits.
- Round-robin pointer: on grant, rr pointer = (winner+1) mod NUM_REQ. With all requesters asserting continuously, grant order is 0,1,2,0,...
- START (1 cycle): tx_start returns to 0; timeout counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: err=1 for one cycle, no done, go to IDLE. The aborted byte is not retried, because ack was already given.
- WAIT_DONE: on tx_busy=0, done[active_id]=1 for one cycle. If GAP_CYCLES>0 go to GAP, else go to IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are not sampled during GAP.
- Requests: a requester must deassert req the cycle after ack, or hold it to queue its next byte. Req deasserted before grant is simply not served; there is no latch of unsampled requests.
- tx_data holds its value from grant until the next grant.
- Simultaneous events:
  - done and a new grant never occur in the same cycle; minimum 1 IDLE cycle between bytes.
  - ack and tx_start always coincide.
  - At most one ack bit is high in any cycle.
  - err and done are never high in the same cycle.
- Counter widths: timeout counter clog2(BUSY_TIMEOUT)+1 bits; gap counter clog2(GAP_CYCLES+1) bits.

Decomposition:
- Shared package uart_pkg: FSM state encoding (localparam codes for IDLE/START/WAIT_BUSY/WAIT_DONE/GAP) and UART byte-width constant BYTE_W=8. The same package is reused by uart_tx/uart_rx.
- One sub-module: rr_priority_pick. Combinational round-robin selector: inputs req vector and pointer; outputs winner index and valid.

Test Plan:
1. Single request: req=3'b010, req_data[15:8]=8'hA5 -> one cycle later ack=3'b010, tx_start=1, tx_data=8'hA5, active_id=1. After the uart_tx frame completes, done=3'b010 once; no err.
2. Contention: req=3'b111 held, data 8'h11/8'h22/8'h33 -> grants 0,1,2,0. Transmitted bytes 11,22,33,11, each completed before the next tx_start.
3. Pointer fairness: grant 2 served, then req=3'b101 -> next grant is 0 (wraps past 2), then 2.
4. Busy timeout: tx_busy stubbed low, BUSY_TIMEOUT=16 -> err pulses exactly 16 cycles after START exits. FSM returns to IDLE, no done, and the next request is granted normally.
5. Gap: GAP_CYCLES=4, back-to-back requests -> 4 cycles in GAP plus 1 IDLE cycle between done and the next tx_start.
6. Reset mid-byte: rst_n=0 during WAIT_DONE -> next edge: all outputs zero, state IDLE. After release, tx_busy falling produces no done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and arbiter state encoding.
// Reused by uart_tx, uart_rx and uart_tx_arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first set req bit
// at or after ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  localparam int IW = $clog2(N);

  // Walk offsets high to low so the nearest one wins.
  always_comb begin
    logic [ID_W:0] cand;
    cand   = '0;
    valid  = 1'b0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(N))
        cand = cand - (ID_W + 1)'(N);
      if (req[cand[IW-1:0]]) begin
        valid  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte
// requesters, with busy-timeout abort and optional gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           active_id
);

  localparam int TO_W  = $clog2(BUSY_TIMEOUT) + 1;
  localparam int GAP_W =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  arb_state_t state, state_n;

  logic [ID_W-1:0]    rr, rr_n;
  logic [ID_W-1:0]    id_n, winner;
  logic               pick_ok;
  logic [BYTE_W-1:0]  data_n;
  logic               start_n, err_n;
  logic [NUM_REQ-1:0] ack_n, done_n;
  logic [TO_W-1:0]    tcnt, tcnt_n;
  logic [GAP_W-1:0]   gcnt, gcnt_n;
  logic [BYTE_W-1:0]  bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  rr_priority_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr),
    .winner (winner),
    .valid  (pick_ok)
  );

  always_comb begin
    state_n = state;
    rr_n    = rr;
    id_n    = active_id;
    data_n  = tx_data;
    start_n = 1'b0;
    ack_n   = '0;
    done_n  = '0;
    err_n   = 1'b0;
    tcnt_n  = tcnt;
    gcnt_n  = gcnt;
    unique case (state)
      IDLE: begin
        if (pick_ok && !tx_busy) begin
          data_n  = bytes[winner];
          start_n = 1'b1;
          ack_n   = NUM_REQ'(1) << winner;
          id_n    = winner;
          rr_n    = (winner == ID_W'(NUM_REQ - 1))
                    ? '0 : winner + 1'b1;
          state_n = START;
        end
      end
      START: begin
        tcnt_n  = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (tcnt == TO_W'(BUSY_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_n = NUM_REQ'(1) << active_id;
          if (GAP_CYCLES > 0) begin
            gcnt_n  = '0;
            state_n = GAP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt == GAP_W'(GAP_CYCLES - 1))
          state_n = IDLE;
        else
          gcnt_n = gcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      active_id <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      ack       <= '0;
      done      <= '0;
      err       <= 1'b0;
      tcnt      <= '0;
      gcnt      <= '0;
    end else begin
      state     <= state_n;
      rr        <= rr_n;
      active_id <= id_n;
      tx_data   <= data_n;
      tx_start  <= start_n;
      ack       <= ack_n;
      done      <= done_n;
      err       <= err_n;
      tcnt      <= tcnt_n;
      gcnt      <= gcnt_n;
    end
  end

endmodule
